// File: rtl/maze_mem_arbiter_if.sv
// maze_mem_arbiter_if: bundles both client handshakes and the maze memory port.
// Client side: req/we/row/col per client in, ack/rdata per client out.
// Memory side: mem_row/mem_col/mem_oe/mem_we out, mem_in read data back.
// Status: busy (not IDLE) and gnt (current or most recent grant).
interface maze_mem_arbiter_if #(parameter int maze_width = 6);
  logic req0, req1, we0, we1, ack0, ack1, rdata0, rdata1;
  logic [maze_width-1:0] row0, col0, row1, col1, mem_row, mem_col;
  logic mem_oe, mem_we, mem_in, busy, gnt;
  modport slave (
    input  req0, req1, we0, we1, row0, col0, row1, col1, mem_in,
    output ack0, ack1, rdata0, rdata1, mem_row, mem_col, mem_oe, mem_we, busy, gnt
  );
  modport master (
    output req0, req1, we0, we1, row0, col0, row1, col1, mem_in,
    input  ack0, ack1, rdata0, rdata1, mem_row, mem_col, mem_oe, mem_we, busy, gnt
  );
endinterface

// File: rtl/maze_mem_arbiter.sv
// maze_mem_arbiter: round-robin arbiter sharing the 1-bit maze memory port between two clients.
// Ports: clk, rst (async, active-high), bus (maze_mem_arbiter_if.slave) carrying
// both client req/ack handshakes, read data returns and the memory strobes/address.
module maze_mem_arbiter #(parameter int maze_width = 6) (
  input logic clk,
  input logic rst,
  maze_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_t;
  state_t state;
  logic last, we_l, sel, sel_we;
  logic [maze_width-1:0] sel_row, sel_col;
  // on a tie the client not granted last wins
  assign sel = (bus.req0 && bus.req1) ? !last : bus.req1;
  assign sel_we = sel ? bus.we1 : bus.we0;
  assign sel_row = sel ? bus.row1 : bus.row0;
  assign sel_col = sel ? bus.col1 : bus.col0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
      we_l <= 1'b0;
      bus.gnt <= 1'b0;
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      bus.rdata0 <= 1'b0;
      bus.rdata1 <= 1'b0;
      bus.mem_oe <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_row <= '0;
      bus.mem_col <= '0;
      bus.busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req0 || bus.req1) begin
          state <= ACCESS;
          bus.gnt <= sel;
          we_l <= sel_we;
          bus.mem_row <= sel_row;
          bus.mem_col <= sel_col;
          bus.mem_oe <= !sel_we;
          bus.mem_we <= sel_we;
          bus.busy <= 1'b1;
        end
        ACCESS: begin
          bus.mem_oe <= 1'b0;
          bus.mem_we <= 1'b0;
          state <= we_l ? DONE : RESP;
          bus.ack0 <= we_l && !bus.gnt;
          bus.ack1 <= we_l && bus.gnt;
        end
        RESP: begin
          if (bus.gnt) bus.rdata1 <= bus.mem_in;
          else bus.rdata0 <= bus.mem_in;
          bus.ack0 <= !bus.gnt;
          bus.ack1 <= bus.gnt;
          state <= DONE;
        end
        DONE: begin
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          last <= bus.gnt;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_maze_mem_arbiter.sv
// tb_maze_mem_arbiter: scoreboard bench with a transaction-level arbiter model and memory model.
module tb_maze_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maze_mem_arbiter_if #(.maze_width(6)) bus();
  maze_mem_arbiter #(.maze_width(6)) dut(.clk(clk), .rst(rst), .bus(bus));

  logic req[2], we[2];
  logic [5:0] row[2], col[2];
  logic mem_in_v = 1'b0, hold = 1'b0;
  assign bus.req0 = req[0];
  assign bus.req1 = req[1];
  assign bus.we0 = we[0];
  assign bus.we1 = we[1];
  assign bus.row0 = row[0];
  assign bus.row1 = row[1];
  assign bus.col0 = col[0];
  assign bus.col1 = col[1];
  assign bus.mem_in = mem_in_v;

  typedef struct {logic we; logic [5:0] row, col;} req_t;
  typedef struct {int c; logic we; logic [5:0] row, col; int t_strobe, t_ack; logic rd0, rd1;} exp_t;

  req_t pl[2][$];
  exp_t sq[$], aq[$];
  exp_t se, ae;
  logic mem_dut[64][64], mem_ref[64][64];
  logic rd_m[2];
  int last_m = 1;
  int cyc = 0, total = 0, passed = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic logic [5:0] pick();
    int k = $urandom_range(0, 4);
    return k == 0 ? 6'd0 : k == 1 ? 6'd63 : 6'($urandom);
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.we = ($urandom_range(0, 2) == 0);
    r.row = pick();
    r.col = pick();
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // memory: data for a read appears after the mem_oe cycle and holds through the next cycle
  always @(negedge clk) begin
    if (bus.mem_we) mem_dut[bus.mem_row][bus.mem_col] = 1'b1;
    if (bus.mem_oe) begin
      mem_in_v = mem_dut[bus.mem_row][bus.mem_col];
      hold = 1'b1;
    end else if (hold) hold = 1'b0;
    else mem_in_v = 1'($urandom);
  end

  always @(negedge clk) if (bus.mem_oe || bus.mem_we) begin
    chk("strobe_exclusive", {31'd0, bus.mem_oe & bus.mem_we}, 0);
    if (sq.size() == 0) begin
      total++;
      $display("FAIL unexpected_strobe: got oe=%0d we=%0d at cycle %0d, required none", bus.mem_oe, bus.mem_we, cyc);
    end else begin
      se = sq.pop_front();
      chk("strobe_cycle", cyc, se.t_strobe);
      chk("mem_we", {31'd0, bus.mem_we}, {31'd0, se.we});
      chk("mem_oe", {31'd0, bus.mem_oe}, {31'd0, !se.we});
      chk("mem_row", {26'd0, bus.mem_row}, {26'd0, se.row});
      chk("mem_col", {26'd0, bus.mem_col}, {26'd0, se.col});
      chk("busy_in_access", {31'd0, bus.busy}, 1);
    end
  end

  always @(negedge clk) if (bus.ack0 || bus.ack1) begin
    chk("ack_exclusive", {31'd0, bus.ack0 & bus.ack1}, 0);
    if (aq.size() == 0) begin
      total++;
      $display("FAIL unexpected_ack: got ack0=%0d ack1=%0d at cycle %0d, required none", bus.ack0, bus.ack1, cyc);
    end else begin
      ae = aq.pop_front();
      chk("ack_cycle", cyc, ae.t_ack);
      chk("ack_client", {31'd0, bus.ack1}, ae.c);
      chk("gnt", {31'd0, bus.gnt}, ae.c);
      chk("rdata0", {31'd0, bus.rdata0}, {31'd0, ae.rd0});
      chk("rdata1", {31'd0, bus.rdata1}, {31'd0, ae.rd1});
      chk("busy_at_ack", {31'd0, bus.busy}, 1);
    end
  end

  task automatic client(input int c, input int n);
    int k;
    for (int j = 0; j < n; j++) begin
      we[c] = pl[c][j].we;
      row[c] = pl[c][j].row;
      col[c] = pl[c][j].col;
      req[c] = 1'b1;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!(c == 1 ? bus.ack1 : bus.ack0) && k < 40);
      if (k >= 40) begin
        total++;
        $display("FAIL client%0d_timeout: got no ack within 40 cycles, required ack", c);
        req[c] = 1'b0;
        return;
      end
    end
    req[c] = 1'b0;
  endtask

  // reference: grants alternate from the client not granted last when both hold requests;
  // each transaction begins in the IDLE cycle after the previous ack
  task automatic run_round();
    int n0 = pl[0].size();
    int n1 = pl[1].size();
    int t = cyc;
    int idx[2] = '{0, 0};
    int order[$];
    int c;
    req_t p;
    exp_t e;
    chk("idle_before_round", {31'd0, bus.busy}, 0);
    if (n0 > 0 && n1 > 0) begin
      for (int i = 0; i < n0 + n1; i++) order.push_back(i % 2 == 0 ? 1 - last_m : last_m);
    end else begin
      for (int i = 0; i < n0 + n1; i++) order.push_back(n0 > 0 ? 0 : 1);
    end
    foreach (order[i]) begin
      c = order[i];
      p = pl[c][idx[c]];
      idx[c]++;
      e.c = c;
      e.we = p.we;
      e.row = p.row;
      e.col = p.col;
      e.t_strobe = t + 1;
      e.t_ack = t + (p.we ? 2 : 3);
      if (p.we) mem_ref[p.row][p.col] = 1'b1;
      else rd_m[c] = mem_ref[p.row][p.col];
      e.rd0 = rd_m[0];
      e.rd1 = rd_m[1];
      sq.push_back(e);
      aq.push_back(e);
      t = e.t_ack + 1;
      last_m = c;
    end
    fork
      client(0, n0);
      client(1, n1);
    join
    pl[0].delete();
    pl[1].delete();
    @(negedge clk);
  endtask

  initial begin
    req_t p;
    exp_t e;
    req = '{1'b0, 1'b0};
    we = '{1'b0, 1'b0};
    row = '{6'd0, 6'd0};
    col = '{6'd0, 6'd0};
    rd_m = '{1'b0, 1'b0};
    for (int r = 0; r < 64; r++)
      for (int k = 0; k < 64; k++) begin
        mem_dut[r][k] = 1'($urandom);
        mem_ref[r][k] = mem_dut[r][k];
      end
    mem_dut[5][9] = 1'b1;
    mem_ref[5][9] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 0);
    chk("reset_gnt", {31'd0, bus.gnt}, 0);
    chk("reset_acks", {30'd0, bus.ack1, bus.ack0}, 0);
    chk("reset_strobes", {30'd0, bus.mem_we, bus.mem_oe}, 0);
    chk("reset_addr", {20'd0, bus.mem_row, bus.mem_col}, 0);
    chk("reset_rdata", {30'd0, bus.rdata1, bus.rdata0}, 0);
    rst = 1'b0;
    @(negedge clk);
    pl[0].push_back('{1'b0, 6'd5, 6'd9});
    run_round();
    pl[1].push_back('{1'b1, 6'd63, 6'd0});
    run_round();
    for (int i = 0; i < 2; i++) begin
      pl[0].push_back(rnd_req());
      pl[0][i].we = 1'b0;
      pl[1].push_back(rnd_req());
      pl[1][i].we = 1'b0;
    end
    run_round();
    pl[0].push_back('{1'b0, 6'd1, 6'd2});
    run_round();
    pl[0].push_back('{1'b0, 6'd7, 6'd7});
    pl[1].push_back('{1'b0, 6'd8, 6'd8});
    run_round();
    pl[0].push_back('{1'b0, 6'd5, 6'd9});
    pl[0].push_back('{1'b0, 6'd5, 6'd9});
    run_round();
    p = rnd_req();
    p.we = 1'b0;
    we[0] = 1'b0;
    row[0] = p.row;
    col[0] = p.col;
    req[0] = 1'b1;
    e.c = 0;
    e.we = 1'b0;
    e.row = p.row;
    e.col = p.col;
    e.t_strobe = cyc + 1;
    e.t_ack = cyc + 3;
    sq.push_back(e);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    req[0] = 1'b0;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_strobes", {30'd0, bus.mem_we, bus.mem_oe}, 0);
    chk("rst_acks", {30'd0, bus.ack1, bus.ack0}, 0);
    chk("rst_gnt", {31'd0, bus.gnt}, 0);
    chk("rst_rdata", {30'd0, bus.rdata1, bus.rdata0}, 0);
    rd_m = '{1'b0, 1'b0};
    last_m = 1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    pl[0].push_back(p);
    run_round();
    for (int r = 0; r < 60; r++) begin
      int mode = $urandom_range(0, 2);
      int n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        if (mode != 1) pl[0].push_back(rnd_req());
        if (mode != 0) pl[1].push_back(rnd_req());
      end
      run_round();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("strobe_queue_drained", sq.size(), 0);
    chk("ack_queue_drained", aq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
